// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bus_pkg                                                    |
// | Purpose : Shared types and constants for the system bus master:      |
// |           one-hot T-state enum, bus widths, strobe levels and the    |
// |           latched request record.                                    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package bus_pkg;

    localparam int BUS_ADDR_W = 20;
    localparam int BUS_DATA_W = 8;

    // Both bus strobes are active-low
    localparam logic RD_ACTIVE = 1'b0;
    localparam logic WR_ACTIVE = 1'b0;

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_T1   = 6'b000010,
        ST_T2   = 6'b000100,
        ST_T3   = 6'b001000,
        ST_TW   = 6'b010000,
        ST_T4   = 6'b100000
    } bus_state_e;

    typedef struct packed {
        logic                  we;
        logic                  iom;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_arbiter2                                                |
// | Purpose : Two-input round-robin arbiter. The pointer selects the     |
// |           winner when both inputs request and flips to the other     |
// |           requester after every accepted grant.                      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       grant_o,
    output logic       valid_o
);

    logic ptr_q;

    // Winner selection: a lone requester wins outright, a tie goes to the pointer
    always_comb begin
        valid_o = |req_i;
        grant_o = 1'b0;
        if (req_i == 2'b11) begin
            grant_o = ptr_q;
        end else begin
            grant_o = req_i[1];
        end
    end

    // Pointer moves to the loser once a grant is actually taken
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_q <= 1'b0;
        end else if (advance_i && valid_o) begin
            ptr_q <= ~grant_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_cycle_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bus_cycle_arbiter                                          |
// | Purpose : Two-requester bus master. Arbitrates round-robin and runs  |
// |           one T1-T2-T3-[Tw]-T4 cycle per grant, driving ALE/IOM/RD/  |
// |           WR/Address/Data and returning a done pulse in T4.          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bus_cycle_arbiter
    import bus_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = BUS_ADDR_W,
    parameter int DATA_W      = BUS_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              iom0,
    input  logic              iom1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] RDATA,
    output logic              ALE,
    output logic              IOM,
    output logic              RD,
    output logic              WR,
    output logic [ADDR_W-1:0] Address,
    inout  wire  [DATA_W-1:0] Data
);

    localparam int       WLAST_I = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
    localparam logic [2:0] WLAST = 3'(WLAST_I);

    bus_state_e        state_q;
    bus_req_t          lat_q;
    logic              gnt_id_q;
    logic [2:0]        wcnt_q;
    logic              drv_q;
    logic              ale_q, iom_q, rd_q, wr_q, done0_q, done1_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;

    logic [1:0] arb_req_d;
    logic       arb_adv_d, arb_grant, arb_valid, finish_d;
    bus_req_t   sel_d;

    // Arbiter view of requests: the requester finishing in T4 is masked out
    always_comb begin
        arb_req_d = {req1, req0};
        if (state_q == ST_T4) begin
            arb_req_d[gnt_id_q] = 1'b0;
        end
        arb_adv_d = (state_q == ST_IDLE) || (state_q == ST_T4);
        finish_d  = ((state_q == ST_T3) && (WAIT_STATES == 0)) ||
                    ((state_q == ST_TW) && (wcnt_q == WLAST));
        if (arb_grant) begin
            sel_d = '{we: we1, iom: iom1, addr: BUS_ADDR_W'(addr1), wdata: BUS_DATA_W'(wdata1)};
        end else begin
            sel_d = '{we: we0, iom: iom0, addr: BUS_ADDR_W'(addr0), wdata: BUS_DATA_W'(wdata0)};
        end
    end

    rr_arbiter2 u_arb (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_i     (arb_req_d),
        .advance_i (arb_adv_d),
        .grant_o   (arb_grant),
        .valid_o   (arb_valid)
    );

    // Bus-cycle sequencer with registered bus outputs; the final-strobe step
    // (end of T3 or last Tw) overrides the per-state transition below it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            lat_q    <= '0;
            gnt_id_q <= 1'b0;
            wcnt_q   <= 3'd0;
            drv_q    <= 1'b0;
            ale_q    <= 1'b0;
            iom_q    <= 1'b0;
            rd_q     <= ~RD_ACTIVE;
            wr_q     <= ~WR_ACTIVE;
            addr_q   <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_T4: begin
                    // Write data is held through T4 and released afterwards
                    drv_q <= 1'b0;
                    if (arb_valid) begin
                        lat_q    <= sel_d;
                        gnt_id_q <= arb_grant;
                        ale_q    <= 1'b1;
                        iom_q    <= sel_d.iom;
                        addr_q   <= ADDR_W'(sel_d.addr);
                        state_q  <= ST_T1;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_T1: begin
                    ale_q <= 1'b0;
                    if (lat_q.we) begin
                        wr_q  <= WR_ACTIVE;
                        drv_q <= 1'b1;
                    end else begin
                        rd_q  <= RD_ACTIVE;
                    end
                    state_q <= ST_T2;
                end
                ST_T2: begin
                    state_q <= ST_T3;
                end
                ST_T3: begin
                    wcnt_q  <= 3'd0;
                    state_q <= ST_TW;
                end
                ST_TW: begin
                    wcnt_q  <= wcnt_q + 3'd1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            if (finish_d) begin
                rd_q    <= ~RD_ACTIVE;
                wr_q    <= ~WR_ACTIVE;
                done0_q <= ~gnt_id_q;
                done1_q <= gnt_id_q;
                if (!lat_q.we) begin
                    rdata_q <= Data;
                end
                state_q <= ST_T4;
            end
        end
    end

    assign Data    = drv_q ? DATA_W'(lat_q.wdata) : {DATA_W{1'bz}};
    assign ALE     = ale_q;
    assign IOM     = iom_q;
    assign RD      = rd_q;
    assign WR      = wr_q;
    assign Address = addr_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign RDATA   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bus_cycle_arbiter                                       |
// | Purpose : Directed self-checking bench for bus_cycle_arbiter with a  |
// |           small RAM model on the bus and an expected-result queue.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_bus_cycle_arbiter;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    // Instance with no wait states
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, iom0 = 0, iom1 = 0;
    logic [19:0] addr0 = 0, addr1 = 0;
    logic [7:0]  wdata0 = 0, wdata1 = 0;
    logic        done0, done1, ALE, IOM, RD, WR;
    logic [7:0]  RDATA;
    logic [19:0] Address;
    wire  [7:0]  Data;

    // Instance with two wait states
    logic        b_req0 = 0;
    logic [19:0] b_addr0 = 0;
    logic        b_done0, b_done1, b_ALE, b_IOM, b_RD, b_WR;
    logic [7:0]  b_RDATA;
    logic [19:0] b_Address;
    wire  [7:0]  b_Data;

    bus_cycle_arbiter #(.WAIT_STATES(0)) dut (
        .CLK(CLK), .RESET(RESET),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .iom0(iom0), .iom1(iom1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .RDATA(RDATA), .ALE(ALE), .IOM(IOM),
        .RD(RD), .WR(WR), .Address(Address), .Data(Data)
    );

    bus_cycle_arbiter #(.WAIT_STATES(2)) dut_w2 (
        .CLK(CLK), .RESET(RESET),
        .req0(b_req0), .req1(1'b0), .we0(1'b0), .we1(1'b0), .iom0(1'b0), .iom1(1'b0),
        .addr0(b_addr0), .addr1(20'h0), .wdata0(8'h00), .wdata1(8'h00),
        .done0(b_done0), .done1(b_done1), .RDATA(b_RDATA), .ALE(b_ALE), .IOM(b_IOM),
        .RD(b_RD), .WR(b_WR), .Address(b_Address), .Data(b_Data)
    );

    // Memory model: answers memory reads only, writes on WR low, preloaded in reset
    logic [7:0] mem [512];
    assign Data = (!RD && !IOM) ? mem[Address[8:0]] : 8'hzz;
    always @(posedge CLK) begin
        if (RESET) begin
            mem[9'h010] <= 8'hA5;
            mem[9'h020] <= 8'h5A;
        end else if (!WR && !IOM) begin
            mem[Address[8:0]] <= Data;
        end
    end
    assign b_Data = (!b_RD && !b_IOM) ? ((b_Address == 20'h00020) ? 8'h5A : 8'h00) : 8'hzz;

    typedef struct {
        logic       id;
        logic       we;
        logic       chk_rd;
        logic [7:0] rdata;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int failures = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic id, input logic we, input logic chk_rd, input logic [7:0] rd);
        exp_t e;
        e.id = id; e.we = we; e.chk_rd = chk_rd; e.rdata = rd;
        sbq.push_back(e);
    endtask

    // Called in the cycle a done pulse is expected
    task automatic sb_pop(input logic d0, input logic d1, input logic [7:0] rd);
        exp_t e;
        chk("sb_nonempty", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("done0", 32'(d0), 32'(!e.id));
            chk("done1", 32'(d1), 32'(e.id));
            if (!e.we && e.chk_rd) chk("rdata", 32'(rd), 32'(e.rdata));
        end
    endtask

    task automatic set_req(input logic id, input logic r, input logic we, input logic iom,
                           input logic [19:0] a, input logic [7:0] wd);
        if (id == 1'b0) begin
            req0 = r; we0 = we; iom0 = iom; addr0 = a; wdata0 = wd;
        end else begin
            req1 = r; we1 = we; iom1 = iom; addr1 = a; wdata1 = wd;
        end
    endtask

    // One isolated cycle on the zero-wait instance, checked phase by phase
    task automatic run_single(input logic id, input logic we, input logic iom, input logic [19:0] a,
                              input logic [7:0] wd, input logic [7:0] rexp, input logic chk_rd);
        set_req(id, 1'b1, we, iom, a, wd);
        sb_push(id, we, chk_rd, rexp);
        tick();
        chk("t1_ale", 32'(ALE), 1);
        chk("t1_addr", 32'(Address), 32'(a));
        chk("t1_iom", 32'(IOM), 32'(iom));
        chk("t1_rd", 32'(RD), 1);
        chk("t1_wr", 32'(WR), 1);
        for (int c = 2; c <= 3; c++) begin
            tick();
            chk("strobe_ale", 32'(ALE), 0);
            chk("strobe_rd", 32'(RD), 32'(we));
            chk("strobe_wr", 32'(WR), 32'(!we));
            chk("strobe_drv", 32'(dut.drv_q), 32'(we));
            chk("strobe_addr", 32'(Address), 32'(a));
            chk("strobe_iom", 32'(IOM), 32'(iom));
            if (we) chk("strobe_data", 32'(Data), 32'(wd));
        end
        tick();
        chk("t4_rd", 32'(RD), 1);
        chk("t4_wr", 32'(WR), 1);
        chk("t4_drv", 32'(dut.drv_q), 32'(we));
        chk("t4_addr", 32'(Address), 32'(a));
        chk("t4_iom", 32'(IOM), 32'(iom));
        if (we) chk("t4_data", 32'(Data), 32'(wd));
        sb_pop(done0, done1, RDATA);
        set_req(id, 1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
        tick();
        chk("idle_done0", 32'(done0), 0);
        chk("idle_done1", 32'(done1), 0);
        chk("idle_drv", 32'(dut.drv_q), 0);
        chk("idle_ale", 32'(ALE), 0);
    endtask

    initial begin
        // Reset state
        RESET = 1'b1;
        tick();
        tick();
        chk("rst_ale", 32'(ALE), 0);
        chk("rst_rd", 32'(RD), 1);
        chk("rst_wr", 32'(WR), 1);
        chk("rst_iom", 32'(IOM), 0);
        chk("rst_addr", 32'(Address), 0);
        chk("rst_done", 32'({done1, done0}), 0);
        chk("rst_rdata", 32'(RDATA), 0);
        chk("rst_drv", 32'(dut.drv_q), 0);
        RESET = 1'b0;
        tick();

        // Single read, then write/read-back on requester 1
        run_single(1'b0, 1'b0, 1'b0, 20'h00010, 8'h00, 8'hA5, 1'b1);
        run_single(1'b1, 1'b1, 1'b0, 20'h00123, 8'h3C, 8'h00, 1'b0);
        run_single(1'b1, 1'b0, 1'b0, 20'h00123, 8'h00, 8'h3C, 1'b1);

        // Contention: both held for four grants, expect 0,1,0,1 with no idle gap
        set_req(1'b0, 1'b1, 1'b0, 1'b0, 20'h00010, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 20'h00123, 8'h00);
        sb_push(1'b0, 1'b0, 1'b1, 8'hA5);
        sb_push(1'b1, 1'b0, 1'b1, 8'h3C);
        sb_push(1'b0, 1'b0, 1'b1, 8'hA5);
        sb_push(1'b1, 1'b0, 1'b1, 8'h3C);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("cont_ale", 32'(ALE), 32'(i % 4 == 1));
            if (i % 4 == 0) begin
                sb_pop(done0, done1, RDATA);
            end else begin
                chk("cont_nodone", 32'({done1, done0}), 0);
            end
            if (i == 16) begin
                set_req(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
                set_req(1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
            end
        end
        tick();
        chk("cont_end_done", 32'({done1, done0}), 0);
        chk("cont_end_ale", 32'(ALE), 0);

        // Reset during T3 of a write aborts without a done pulse
        set_req(1'b0, 1'b1, 1'b1, 1'b0, 20'h00050, 8'h77);
        tick();
        tick();
        tick();
        chk("abort_t3_wr", 32'(WR), 0);
        chk("abort_t3_drv", 32'(dut.drv_q), 1);
        RESET = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
        tick();
        chk("abort_rd", 32'(RD), 1);
        chk("abort_wr", 32'(WR), 1);
        chk("abort_ale", 32'(ALE), 0);
        chk("abort_drv", 32'(dut.drv_q), 0);
        chk("abort_done", 32'({done1, done0}), 0);
        RESET = 1'b0;
        tick();
        chk("abort_late_done", 32'({done1, done0}), 0);
        run_single(1'b0, 1'b1, 1'b0, 20'h00050, 8'h77, 8'h00, 1'b0);
        run_single(1'b0, 1'b0, 1'b0, 20'h00050, 8'h00, 8'h77, 1'b1);

        // I/O cycle: IOM held high, nothing drives the data bus
        run_single(1'b0, 1'b0, 1'b1, 20'h00040, 8'h00, 8'h00, 1'b0);

        // Two wait states: RD low for four cycles, done in cycle six
        b_req0  = 1'b1;
        b_addr0 = 20'h00020;
        sb_push(1'b0, 1'b0, 1'b1, 8'h5A);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("w2_addr", 32'(b_Address), 32'h00020);
            chk("w2_ale", 32'(b_ALE), 32'(i == 1));
            chk("w2_rd", 32'(b_RD), 32'(!(i >= 2 && i <= 5)));
            chk("w2_wr", 32'(b_WR), 1);
            if (i == 6) begin
                sb_pop(b_done0, b_done1, b_RDATA);
                b_req0 = 1'b0;
            end else begin
                chk("w2_nodone", 32'({b_done1, b_done0}), 0);
            end
        end
        tick();
        chk("w2_end_done", 32'({b_done1, b_done0}), 0);

        chk("sb_drained", 32'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_cycle_arbiter.md
Name: bus_cycle_arbiter

Overview:
- Two-requester bus master for the 8-bit, 20-bit-address, multiplexed-style system bus served by the 2142 RAM model and I/O devices.
- Accepts read/write requests from requester 0 (CPU core) and requester 1 (DMA/loader), arbitrates round-robin and runs one T1-T2-T3-[Tw]-T4 bus cycle per grant.
- Drives ALE/IOM/RD/WR/Address/Data, captures read data and returns a one-cycle done pulse to the granted requester.

Parameters:
- WAIT_STATES, 0, number of Tw cycles inserted between T3 and T4 (0..7).
- ADDR_W, 20, bus address width.
- DATA_W, 8, bus data width.

Ports:
- CLK  input  1  bus clock; all logic on posedge.
- RESET  input  1  synchronous, active-high reset.
- req0, req1  input  1 each  request; held high until matching done.
- we0, we1  input  1 each  1 = write, 0 = read; stable while req high.
- iom0, iom1  input  1 each  1 = I/O cycle, 0 = memory cycle.
- addr0, addr1  input  ADDR_W each  cycle address.
- wdata0, wdata1  input  DATA_W each  write data.
- done0, done1  output  1 each  one-cycle completion pulse in T4.
- RDATA  output  DATA_W  captured read data; valid when done is high, held until the next capture.
- ALE  output  1  address latch enable, high only in T1.
- IOM  output  1  cycle type to bus.
- RD  output  1  active-low read strobe.
- WR  output  1  active-low write strobe.
- Address  output  ADDR_W  bus address.
- Data  inout  DATA_W  bidirectional bus data; Hi-Z unless the block is driving write data.

Behaviour:
- Reset values (synchronous, RESET high at posedge):
  - state IDLE; ALE=0; RD=1; WR=1; IOM=0; Address=0; Data=Hi-Z.
  - done0=done1=0; RDATA=0; priority pointer=0.
- States: IDLE, T1, T2, T3, TW, T4; one-hot encoding.
- IDLE: on any req, latch the winner's we/iom/addr/wdata and go to T1. Otherwise stay in IDLE.
- T1: ALE=1; Address and IOM driven from latched values. Go to T2.
- T2: ALE=0; RD=0 for a read, or WR=0 with Data driven for a write. Go to T3.
- T3: strobe held. Go to TW if WAIT_STATES>0, else to T4.
  - For a read with WAIT_STATES=0, RDATA captures Data at the posedge ending T3.
- TW: strobe held; a wait counter counts WAIT_STATES cycles.
  - RDATA captures Data at the posedge ending the last TW.
  - Go to T4.
- T4:
  - RD=1, WR=1.
  - Write data is still driven in T4 (hold time); Data=Hi-Z from the following cycle.
  - done of the granted requester is high.
  - Then go to T1 directly if any req is pending, excluding the requester being completed this cycle; otherwise go to IDLE.
  - Back-to-back cycles therefore have no idle gap.
- Address and IOM are stable T1 through T4. Latched request fields do not change mid-cycle even if requester inputs change.
- Arbitration (round-robin):
  - Only req0 pending -> 0; only req1 pending -> 1.
  - Both pending -> the requester the pointer selects.
  - After each grant the pointer moves to the other requester. Simultaneous continuous requests therefore alternate 0,1,0,1.
- The completed requester's req is ignored in its own T4 cycle, so a held-high req is not regranted twice.
- Data is driven only for writes and only in T2..T4. It is never driven during a read or in IDLE, which guarantees no contention with the RAM read driver.
- RESET mid-cycle: abort at the next posedge.
  - Strobes go inactive and Data goes Hi-Z.
  - No done pulse is issued; the aborted requester must re-request.
- Latency:
  - Read or write from req (in IDLE) to done = 4 + WAIT_STATES cycles.
  - Bus occupancy per cycle = 4 + WAIT_STATES cycles.

Decomposition:
- Shared package bus_pkg holds:
  - the T-state enum, one-hot 6-bit;
  - constants BUS_ADDR_W=20 and BUS_DATA_W=8;
  - strobe levels RD_ACTIVE=0 and WR_ACTIVE=0;
  - the request struct {we, iom, addr, wdata}.
- One sub-module, rr_arbiter2: 2-input round-robin arbiter with a registered pointer, a grant output and an advance input.
- The FSM, request latch, wait counter and data tristate remain in bus_cycle_arbiter.

Test Plan:
- Single read, WAIT_STATES=0: req0 read, addr0=20'h00010, RAM preloaded 8'hA5.
  -> ALE high in cycle 1, RD low in cycles 2-3, done0 in cycle 4, RDATA=8'hA5.
- Single write then read: req1 write, addr1=20'h00123, wdata1=8'h3C; then req1 read of the same address.
  -> WR low for 2 cycles, Data=8'h3C in T2-T4; the read returns 8'h3C.
- Contention: req0 and req1 both high and held for 4 grants.
  -> grant order 0,1,0,1; each done is a single pulse; no gap between T4 and the next T1.
- WAIT_STATES=2 read: req0 read of 20'h00020 (preloaded 8'h5A).
  -> RD low for 4 cycles, done0 in cycle 6, RDATA=8'h5A; Address constant across all 6 cycles.
- RESET asserted during T3 of a write.
  -> next cycle: RD=WR=1, Data=Hi-Z, ALE=0, no done; after release a new req0 completes normally.
- I/O cycle: req0 with iom0=1, addr0=20'h00040.
  -> IOM=1 through T1-T4; RAM does not respond (Data stays Hi-Z on read, RDATA=8'hZZ/X flagged by the checker as expected for an unbacked I/O port).
